// File: rtl/booth_recoder_seq.sv
// Sequential radix-4 modified-Booth recoder and accumulator controller for an OP_W x OP_W unsigned multiply.
// Define BOOTH_ABORT_EN to let abort in LOAD/RUN restart the pass on the captured operands.
module booth_recoder_seq #(
  parameter int OP_W = 8,
  parameter int MD_W = OP_W + 3,
  parameter int NDIG = (OP_W + 2) / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] mcand,
  input  logic [OP_W-1:0] mplier,
  input  logic            abort,
  output logic [MD_W-1:0] md,
  output logic            cla_sub,
  output logic            load,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   m_q, m_d;
  logic [MD_W-1:0]   b_q, b_d;

  logic [2:0]        trip;
  logic [MD_W-1:0]   mag1;
  logic [MD_W-1:0]   mag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      b_q     <= b_d;
    end
  end

  // B keeps a zero below the LSB so digit i is simply B[2i+2:2i]; B is never shifted so an abort can replay it.
  assign trip = 3'(b_q >> {cnt_q, 1'b0});
  assign mag1 = MD_W'(m_q);
  assign mag2 = MD_W'({m_q, 1'b0});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          b_d     = {2'b00, mplier, 1'b0};
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BOOTH_ABORT_EN
    if (abort && (state_q == LOAD || state_q == RUN)) begin
      cnt_d   = '0;
      state_d = LOAD;
    end
`endif
  end

`ifndef BOOTH_ABORT_EN
  logic abort_unused;
  assign abort_unused = abort;
`endif

  always_comb begin
    md      = '0;
    cla_sub = 1'b0;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        // Negative multiples go out ones-complemented; cla_sub supplies the +1.
        case (trip)
          3'b001, 3'b010: md = mag1;
          3'b011:         md = mag2;
          3'b100: begin
            md      = ~mag2;
            cla_sub = 1'b1;
          end
          3'b101, 3'b110: begin
            md      = ~mag1;
            cla_sub = 1'b1;
          end
          default: md = '0;
        endcase
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_recoder_seq.sv
// Directed bench for booth_recoder_seq: a behavioural accumulator rebuilds the product from md/cla_sub and a scoreboard
// holds the expected operands/products; BOOTH_ABORT_EN selects the expected abort behaviour.
module tb_booth_recoder_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic [10:0] md;
  logic        cla_sub;
  logic        load;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          busy_n;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          load_cyc[$];
  int          done_cyc[$];
  int          acc = 0;
  int          ndig = 0;
  int          nbusy = 0;
  logic [10:0] dig_md[5];
  logic        dig_cla[5];

`ifdef BOOTH_ABORT_EN
  localparam int ABORT_BUSY = 9;
`else
  localparam int ABORT_BUSY = 6;
`endif

  always #5 clk = ~clk;

  booth_recoder_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .abort  (abort),
    .md     (md),
    .cla_sub(cla_sub),
    .load   (load),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference digit selection straight from the Booth table.
  function automatic void exp_digit(input logic [7:0] m, input logic [7:0] b, input int i,
                                    output logic [10:0] emd, output logic ecla);
    logic [10:0] bb;
    logic [2:0]  t;
    bb = {2'b00, b, 1'b0};
    t  = bb[2*i +: 3];
    case (t)
      3'b001, 3'b010: begin emd = {3'b000, m};        ecla = 1'b0; end
      3'b011:         begin emd = {2'b00, m, 1'b0};   ecla = 1'b0; end
      3'b100:         begin emd = ~{2'b00, m, 1'b0};  ecla = 1'b1; end
      3'b101, 3'b110: begin emd = ~{3'b000, m};       ecla = 1'b1; end
      default:        begin emd = 11'h000;            ecla = 1'b0; end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [10:0] emd;
    logic        ecla;
    int          v;
    if (rst) begin
      acc   = 0;
      ndig  = 0;
      nbusy = 0;
    end else begin
      cyc++;
      if (busy) nbusy++;
      if (load) begin
        load_cyc.push_back(cyc);
        chk("load_md", md, 0);
        chk("load_cla", cla_sub, 0);
        acc  = 0;
        ndig = 0;
      end else if (busy) begin
        if (sb.size() == 0 || ndig >= 5) begin
          chk("unexpected_digit", 1, 0);
        end else begin
          exp_digit(sb[0].a, sb[0].b, ndig, emd, ecla);
          chk("digit_md", md, emd);
          chk("digit_cla", cla_sub, ecla);
          dig_md[ndig]  = md;
          dig_cla[ndig] = cla_sub;
        end
        v   = int'($signed(md)) + int'(cla_sub);
        acc = acc + v * (1 << (2 * ndig));
        ndig++;
      end
      if (done) begin
        done_cyc.push_back(cyc);
        chk("done_md", md, 0);
        chk("done_cla", cla_sub, 0);
        chk("done_busy", busy, 0);
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("product", acc, {16'h0000, sb[0].prod});
          chk("ndigits", ndig, 5);
          chk("busy_cycles", nbusy, sb[0].busy_n);
          void'(sb.pop_front());
        end
        nbusy = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input int busy_n);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    sb.push_back('{a, b, p, busy_n});
  endtask

  // Drives a one-cycle start; returns with the bench in the LOAD cycle.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input int busy_n, output int k0);
    mcand = a;
    mplier = b;
    start = 1'b1;
    push_exp(a, b, busy_n);
    k0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic settle_and_check(input string tag, input int k0, input int nsteps,
                                  input int l0, input int l1, input int d0, input int d1);
    repeat (nsteps) step();
    chk({tag, "_nload"}, load_cyc.size(), (l1 < 0) ? 1 : 2);
    chk({tag, "_load0"}, (load_cyc.size() > 0) ? load_cyc[0] - k0 : -1, l0);
    if (l1 >= 0) chk({tag, "_load1"}, (load_cyc.size() > 1) ? load_cyc[1] - k0 : -1, l1);
    chk({tag, "_ndone"}, done_cyc.size(), (d1 < 0) ? 1 : 2);
    chk({tag, "_done0"}, (done_cyc.size() > 0) ? done_cyc[0] - k0 : -1, d0);
    if (d1 >= 0) chk({tag, "_done1"}, (done_cyc.size() > 1) ? done_cyc[1] - k0 : -1, d1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    load_cyc.delete();
    done_cyc.delete();
  endtask

  initial begin
    int k0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mcand = 8'h00;
    mplier = 8'h00;
    #1;
    chk("rst_md", md, 0);
    chk("rst_cla", cla_sub, 0);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Reset asserted during the third digit.
    start_op(8'h3C, 8'h5A, 6, k0);
    step();
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_md", md, 0);
    chk("midrst_cla", cla_sub, 0);
    chk("midrst_load", load, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    sb.delete();
    load_cyc.delete();
    done_cyc.delete();
    step();
    rst = 1'b0;
    step();

    start_op(8'h03, 8'h02, 6, k0);
    settle_and_check("p3x2", k0, 10, 1, -1, 7, -1);
    chk("p3x2_d0_md", dig_md[0], 11'h7F9);
    chk("p3x2_d0_cla", dig_cla[0], 1);
    chk("p3x2_d1_md", dig_md[1], 11'h003);
    chk("p3x2_d1_cla", dig_cla[1], 0);
    for (int i = 2; i < 5; i++) begin
      chk("p3x2_dhi_md", dig_md[i], 0);
      chk("p3x2_dhi_cla", dig_cla[i], 0);
    end

    start_op(8'hFF, 8'hFF, 6, k0);
    settle_and_check("pffxff", k0, 10, 1, -1, 7, -1);
    chk("pffxff_d0_md", dig_md[0], 11'h700);
    chk("pffxff_d0_cla", dig_cla[0], 1);
    for (int i = 1; i < 4; i++) chk("pffxff_dmid_md", dig_md[i], 0);
    chk("pffxff_d4_md", dig_md[4], 11'h0FF);
    chk("pffxff_d4_cla", dig_cla[4], 0);

    start_op(8'h00, 8'hA5, 6, k0);
    settle_and_check("p0xa5", k0, 10, 1, -1, 7, -1);
    start_op(8'hA5, 8'h00, 6, k0);
    settle_and_check("pa5x0", k0, 10, 1, -1, 7, -1);

    // start with new operands during RUN is ignored; operand changes after capture are harmless.
    start_op(8'h37, 8'h29, 6, k0);
    step();
    mcand = 8'hEE;
    mplier = 8'hDD;
    start = 1'b1;
    step();
    start = 1'b0;
    settle_and_check("ign", k0, 12, 1, -1, 7, -1);

    // start held high across two operations.
    mcand = 8'h80;
    mplier = 8'h80;
    start = 1'b1;
    push_exp(8'h80, 8'h80, 6);
    k0 = cyc;
    step();
    mcand = 8'h0C;
    mplier = 8'h0B;
    push_exp(8'h0C, 8'h0B, 6);
    repeat (8) step();
    start = 1'b0;
    settle_and_check("b2b", k0, 14, 1, 9, 7, 15);

    // abort in the second RUN cycle.
    start_op(8'hFF, 8'h02, ABORT_BUSY, k0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
`ifdef BOOTH_ABORT_EN
    settle_and_check("abort", k0, 10, 1, 4, 10, -1);
`else
    settle_and_check("abort", k0, 10, 1, -1, 7, -1);
`endif

    abort = 1'b1;
    step();
    step();
    chk("abort_idle_load", load, 0);
    chk("abort_idle_busy", busy, 0);
    abort = 1'b0;

    for (int i = 0; i < 4; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 6, k0);
      settle_and_check("rand", k0, 10, 1, -1, 7, -1);
    end

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_recoder_seq.md
Name: booth_recoder_seq

Overview:
- Sequential radix-4 modified-Booth recoder and controller for the 8-bit unsigned multiplier.
- Drives the partial-product accumulator: one `load` pulse to clear it, then one selected multiple (`md`, `cla_sub`) per clock for 5 cycles, LSB digit first.
- The accumulator shifts right 2 bits per clock; after the last digit its `res[15:0]` holds the unsigned product, signalled by `done`.

Parameters:
- OP_W, 8, operand width (unsigned multiplicand and multiplier)
- MD_W, 11, width of `md` bus (OP_W+3)
- NDIG, 5, Booth digits per product ((OP_W+2)/2; multiplier zero-extended by 2 bits)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- mcand  input  OP_W  multiplicand; captured on accepted start
- mplier  input  OP_W  multiplier; captured on accepted start
- abort  input  1  cancel in-flight multiply (used only with BOOTH_ABORT_EN)
- md  output  MD_W  selected multiple to accumulator (ones-complemented when negative)
- cla_sub  output  1  carry-in to accumulator adder; 1 for negative digits
- load  output  1  accumulator clear pulse
- busy  output  1  high in LOAD and RUN
- done  output  1  one-cycle pulse; accumulator result valid this cycle

Behaviour:
- Single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state=IDLE. Outputs md=0, cla_sub=0, load=0, busy=0, done=0. Operand registers=0, digit counter=0.
- All outputs are registered-state decodes; no combinational path from inputs to outputs.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start=1 → capture mcand into M, capture {2'b00,mplier,1'b0} into the 11-bit B register, go to LOAD.
  - LOAD (1 cycle): load=1, md=0, cla_sub=0, busy=1 → RUN with cnt=0.
  - RUN (NDIG cycles): busy=1. Digit i uses triplet t = B[2i+2:2i], i.e. (b2i+1, b2i, b2i−1). cnt increments each cycle. After cnt==NDIG−1 → DONE.
  - DONE (1 cycle): done=1, md=0, cla_sub=0 → IDLE.
- Digit decode (P = zero-extended MD_W-bit magnitude):
  - 000/111 → 0: md=0, cla_sub=0
  - 001/010 → +M: md={3'b0,M}, cla_sub=0
  - 011 → +2M: md={2'b0,M,1'b0}, cla_sub=0
  - 100 → −2M: md=~{2'b0,M,1'b0}, cla_sub=1
  - 101/110 → −M: md=~{3'b0,M}, cla_sub=1
- The top digit always sees b9=b8=0, so it is never negative. The unsigned product never overflows 16 bits.
- Latency:
  - start accepted at edge k: load high in cycle k+1.
  - Digits in cycles k+2..k+6.
  - done in cycle k+7, coincident with the valid accumulator result.
  - Next start accepted in IDLE at edge k+8 at the earliest.
- start outside IDLE is ignored; no queuing. start held high re-triggers on each return to IDLE.
- mcand/mplier changes after capture have no effect.
- rst mid-operation: immediate return to IDLE with all outputs 0. The accumulator is cleared by its own reset.
- abort without BOOTH_ABORT_EN: ignored.

Optional Feature:
- Macro: BOOTH_ABORT_EN.
- Defined:
  - abort=1 in LOAD or RUN → next state LOAD. This gives one load pulse to clear the accumulator, then the FSM restarts RUN with cnt=0 on the already-captured operands. done is not asserted for the aborted pass.
  - If abort and start are both high in RUN, start is still ignored.
  - abort in IDLE/DONE: no effect.
- Undefined: abort has no effect; the port remains but is unused.

Test Plan:
- Reset mid-RUN: assert rst during the 3rd digit → outputs 0 asynchronously. After release, start with mcand=8'h03, mplier=8'h02 → sequence is LOAD; then (md=11'h7F9, cla_sub=1); then (11'h003, 0); then three × (0, 0); then done. Accumulator res=16'h0006.
- mcand=8'hFF, mplier=8'hFF → digit0 md=11'h700, cla_sub=1; digits1-3 md=0; digit4 md=11'h0FF, cla_sub=0. res=16'hFE01 on done.
- mcand=8'h00, mplier=8'hA5, and separately mcand=8'hA5, mplier=8'h00 → res=0 both times. done exactly 7 cycles after start.
- start pulsed during RUN with different operands → ignored. Product is for the original operands. busy stays high 6 cycles; done asserts once.
- Back-to-back: start held high → second LOAD issued the cycle after IDLE re-entry. Products 8'h80×8'h80=16'h4000, then 8'h0C×8'h0B=16'h0084.
- BOOTH_ABORT_EN: abort in the 2nd RUN cycle of 8'hFF×8'h02 → load re-pulses, 5 digits replay, done once. res=16'h01FE.
